// File: rtl/snail_seq_pkg.sv
// Shared types and defaults for the serial pattern sequencer.
//   state_e : sequencer FSM states (IDLE, SHIFT, DONE)
//   *_DEF   : default word / pattern / divider widths
//   CNT_W   : width needed to count 0..word_w inclusive
package snail_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned WORD_W_DEF = 16;
  localparam int unsigned PAT_W_DEF  = 5;
  localparam int unsigned DIV_W_DEF  = 8;

  function automatic int unsigned CNT_W(input int unsigned word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/snail_rate_div.sv
// Bit-period divider for the serial sequencer.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart the period count (run accepted)
//   run      : count while high
//   div_q    : bit period in clk cycles (always >= 1)
//   tick     : single-cycle strobe on the last cycle of each period
module snail_rate_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] div_q,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  // Combinational from registers so the strobe lands in the same cycle the
  // count reaches the end of the period.
  assign tick = run && (cnt_q == div_q - DIV_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= tick ? '0 : cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/snail_seq_ctrl.sv
// Serialises a parallel word MSB-first on (ser_en, ser_a) at a programmable
// bit period and runs an overlapping pattern matcher on the same stream.
//   start/data_in/pattern/div : run request and its parameters (sampled on accept)
//   busy      : run in progress (SHIFT)
//   ser_en    : valid serial bit strobe; ser_a : current serial bit
//   match     : pulse the cycle after the bit completing the pattern
//   match_cnt : matches in current/last run, held until the next accept
//   done      : one-cycle end-of-run pulse
module snail_seq_ctrl
  import snail_seq_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned PAT_W  = PAT_W_DEF,
  parameter int unsigned DIV_W  = DIV_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WORD_W-1:0]          data_in,
  input  logic [PAT_W-1:0]           pattern,
  input  logic [DIV_W-1:0]           div,
  output logic                       busy,
  output logic                       ser_en,
  output logic                       ser_a,
  output logic                       match,
  output logic [CNT_W(WORD_W)-1:0]   match_cnt,
  output logic                       done
);

  localparam int unsigned CW = CNT_W(WORD_W);

  state_e            state_q;
  logic [WORD_W-1:0] shift_q;
  logic [PAT_W-1:0]  pat_q;
  logic [DIV_W-1:0]  div_q;
  logic [PAT_W-2:0]  hist_q;
  logic [CW-1:0]     bit_cnt_q;
  logic [CW-1:0]     cnt_q;
  logic              match_q;
  logic              done_q;

  logic              accept;
  logic              run;
  logic              tick;
  logic [PAT_W-1:0]  window_d;
  logic              hit_d;
  logic              last_d;

  assign accept = (state_q == IDLE) && start;
  assign run    = (state_q == SHIFT);

  snail_rate_div #(
    .DIV_W (DIV_W)
  ) u_rate_div (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .run   (run),
    .div_q (div_q),
    .tick  (tick)
  );

  // Window ending at the bit currently on ser_a; history is never flushed
  // on a hit so overlapping occurrences are all counted.
  assign window_d = {hist_q, shift_q[WORD_W-1]};
  assign hit_d    = tick && (bit_cnt_q >= CW'(PAT_W - 1)) && (window_d == pat_q);
  assign last_d   = tick && (bit_cnt_q == CW'(WORD_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      pat_q     <= '0;
      div_q     <= '0;
      hist_q    <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      match_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      match_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q   <= data_in;
            pat_q     <= pattern;
            div_q     <= (div == '0) ? DIV_W'(1) : div;
            hist_q    <= '0;
            bit_cnt_q <= '0;
            cnt_q     <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            hist_q    <= window_d[PAT_W-2:0];
            shift_q   <= {shift_q[WORD_W-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + CW'(1);
            match_q   <= hit_d;
            if (hit_d) begin
              cnt_q <= cnt_q + CW'(1);
            end
            if (last_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = run;
  assign ser_en    = tick;
  assign ser_a     = run && shift_q[WORD_W-1];
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign done      = done_q;

endmodule

// File: tb/tb_snail_seq_ctrl.sv
module tb_snail_seq_ctrl;

  localparam int W  = 16;
  localparam int P  = 5;
  localparam int D  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  data_in;
  logic [P-1:0]  pattern;
  logic [D-1:0]  div;
  logic          busy;
  logic          ser_en;
  logic          ser_a;
  logic          match;
  logic [CW-1:0] match_cnt;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  snail_seq_ctrl #(
    .WORD_W (W),
    .PAT_W  (P),
    .DIV_W  (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .pattern   (pattern),
    .div       (div),
    .busy      (busy),
    .ser_en    (ser_en),
    .ser_a     (ser_a),
    .match     (match),
    .match_cnt (match_cnt),
    .done      (done)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: does the serial stream (MSB first) end a pattern occurrence at bit j?
  function automatic bit bit_match(input logic [W-1:0] d, input logic [P-1:0] p, input int j);
    logic [W-1:0] tmp;
    if (j < P - 1) return 1'b0;
    tmp = d >> (W - 1 - j);
    return tmp[P-1:0] == p;
  endfunction

  // Must be entered just after a rising edge with the DUT idle.
  // Cycle k=1 is the cycle following the start-accept edge.
  task automatic run_scenario(input string name, input logic [W-1:0] d, input logic [P-1:0] p,
                              input logic [D-1:0] dv, input int exp_total,
                              input int intrude_k, input bit start_at_done);
    int eff, len, e_cnt;
    bit e_busy, e_en, e_a, e_match, e_done;
    eff = (dv == 0) ? 1 : int'(dv);
    len = W * eff;
    data_in = d; pattern = p; div = dv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= len + 2; k++) begin
      data_in = W'($urandom); pattern = P'($urandom); div = D'($urandom);
      e_busy  = (k <= len);
      e_en    = (k <= len) && (k % eff == 0);
      e_a     = (k <= len) ? d[W - 1 - (k - 1) / eff] : 1'b0;
      e_match = 1'b0;
      if (k >= eff + 1 && (k - 1) % eff == 0 && (k - 1) / eff <= W)
        e_match = bit_match(d, p, (k - 1) / eff - 1);
      e_cnt = 0;
      for (int j = 0; j < W; j++)
        if (bit_match(d, p, j) && (j + 1) * eff + 1 <= k) e_cnt++;
      e_done = (k == len + 1);

      n_checks++; if (busy !== e_busy)
        begin n_fail++; $display("FAIL %s busy k=%0d got %b exp %b", name, k, busy, e_busy); end
      n_checks++; if (ser_en !== e_en)
        begin n_fail++; $display("FAIL %s ser_en k=%0d got %b exp %b", name, k, ser_en, e_en); end
      n_checks++; if (ser_a !== e_a)
        begin n_fail++; $display("FAIL %s ser_a k=%0d got %b exp %b", name, k, ser_a, e_a); end
      n_checks++; if (match !== e_match)
        begin n_fail++; $display("FAIL %s match k=%0d got %b exp %b", name, k, match, e_match); end
      n_checks++; if (match_cnt !== CW'(e_cnt))
        begin n_fail++; $display("FAIL %s match_cnt k=%0d got %0d exp %0d", name, k, match_cnt, e_cnt); end
      n_checks++; if (done !== e_done)
        begin n_fail++; $display("FAIL %s done k=%0d got %b exp %b", name, k, done, e_done); end

      if (k == intrude_k) start = 1'b1;
      else if (start_at_done && k == len + 1) start = 1'b1;
      else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (exp_total >= 0) begin
      n_checks++; if (match_cnt !== CW'(exp_total))
        begin n_fail++; $display("FAIL %s total got %0d exp %0d", name, match_cnt, exp_total); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; data_in = '0; pattern = '0; div = '0;
    #12;
    n_checks++; if ({busy, ser_en, ser_a, match, match_cnt, done} !== '0)
      begin n_fail++; $display("FAIL reset outputs got %b exp 0", {busy, ser_en, ser_a, match, match_cnt, done}); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_pattern_match();
    run_scenario("match_div1", 16'hB6C0, 5'b10110, 8'd1, 3, 0, 1'b0);
  endtask

  task automatic test_rate_div();
    run_scenario("div4", 16'hB6C0, 5'b10110, 8'd4, 3, 0, 1'b0);
    run_scenario("div0", 16'hB6C0, 5'b10110, 8'd0, 3, 0, 1'b0);
  endtask

  task automatic test_overlap_zero();
    run_scenario("zeros", 16'h0000, 5'b00000, 8'd1, 12, 0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_scenario("busy_start", 16'hB6C0, 5'b10110, 8'd2, 3, 10, 1'b1);
    run_scenario("after_busy", 16'h0F0F, 5'b11111, 8'd1, 0, 0, 1'b0);
  endtask

  task automatic test_reset_midrun();
    data_in = 16'hB6C0; pattern = 5'b10110; div = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({busy, ser_en, ser_a, match, match_cnt, done} !== '0)
      begin n_fail++; $display("FAIL rst_mid outputs got %b exp 0", {busy, ser_en, ser_a, match, match_cnt, done}); end
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      n_checks++; if (done !== 1'b0 || busy !== 1'b0)
        begin n_fail++; $display("FAIL rst_mid idle i=%0d got done=%b busy=%b exp 0", i, done, busy); end
      @(posedge clk); #1;
    end
    run_scenario("post_reset", 16'hB6C0, 5'b10110, 8'd1, 3, 0, 1'b0);
  endtask

  task automatic test_edge_ones();
    run_scenario("ones", 16'hFFFF, 5'b11111, 8'd1, 12, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (match_cnt !== CW'(12))
        begin n_fail++; $display("FAIL hold_cnt i=%0d got %0d exp 12", i, match_cnt); end
      @(posedge clk); #1;
    end
    run_scenario("after_ones", 16'h1234, 5'b11111, 8'd3, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] d, tmp;
    logic [P-1:0] p;
    logic [D-1:0] dv;
    int pos;
    for (int r = 0; r < 14; r++) begin
      d  = W'($urandom);
      dv = D'($urandom_range(0, 5));
      if (r % 2 == 0) begin
        pos = $urandom_range(P - 1, W - 1);
        tmp = d >> (W - 1 - pos);
        p   = tmp[P-1:0];
      end else begin
        p = P'($urandom);
      end
      run_scenario("random", d, p, dv, -1, (r % 3 == 0) ? $urandom_range(1, 12) : 0, r[0]);
    end
  endtask

  initial begin
    test_reset();
    test_pattern_match();
    test_rate_div();
    test_overlap_zero();
    test_start_while_busy();
    test_reset_midrun();
    test_edge_ones();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
